// File: rtl/my_bin2bcd_pkg.sv
// my_bin2bcd_pkg
//   Shared constants and helpers for the binary-to-BCD converter.
//   - BCD_W       : bits per BCD digit (4)
//   - ADJ_THRESH  : digit value at or above which +3 is applied before a shift (5)
//   - MAX_DIGITS  : widest digit count the all-nines generator supports
//   - all_nines() : packed pattern with the low n digits set to 9, used as the
//                   saturated result when a conversion overflows
//   - state_t     : converter FSM states
package my_bin2bcd_pkg;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned ADJ_THRESH = 5;
   localparam int unsigned MAX_DIGITS = 32;

   typedef enum logic {
      ST_IDLE,
      ST_CONV
   } state_t;

   function automatic logic [MAX_DIGITS*BCD_W-1:0] all_nines(input int unsigned n);
      logic [MAX_DIGITS*BCD_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < n) begin
            r[i*BCD_W +: BCD_W] = 4'h9;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/my_bcd_adj3.sv
// my_bcd_adj3
//   Combinational double-dabble digit correction: a digit of 5 or more gets +3
//   so that the following left shift carries correctly into the next digit.
//   Ports:
//     digit : in,  one BCD digit from the scratch register
//     adj   : out, corrected digit (4-bit wrap, no carry out)
module my_bcd_adj3
   import my_bin2bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   output logic [BCD_W-1:0] adj
);

   assign adj = (digit >= BCD_W'(ADJ_THRESH)) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/my_bin2bcd.sv
// my_bin2bcd
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   A conversion takes W shift edges after the accepting edge; the result is
//   held on bcd until the next done pulse. Values >= 10^N saturate to all nines
//   with ovf set.
//   Parameters:
//     W : binary input width (1..32)
//     N : number of BCD digits, digit 0 in bcd[3:0]
//   Ports:
//     clk      : rising-edge clock
//     rst      : asynchronous active-high reset
//     start    : request a conversion (sampled only while idle)
//     bin      : value to convert, captured on the accepting edge
//     busy     : conversion in progress
//     done     : one-cycle pulse when bcd/ovf/digit_en have just updated
//     bcd      : packed BCD result
//     ovf      : last result overflowed
//     digit_en : per-digit display enable
//   Build option:
//     MY_BIN2BCD_LZB_EN : when defined, digit_en blanks leading zero digits
//                         (digit 0 always enabled); otherwise digit_en is all ones.
module my_bin2bcd
   import my_bin2bcd_pkg::*;
#(
   parameter int unsigned W = 14,
   parameter int unsigned N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     bin,
   output logic             busy,
   output logic             done,
   output logic [N*4-1:0]   bcd,
   output logic             ovf,
   output logic [N-1:0]     digit_en
);

   localparam int unsigned CNT_W = $clog2(W + 1);
   localparam int unsigned BCD_BITS = N * BCD_W;
   localparam logic [MAX_DIGITS*BCD_W-1:0] NINES_FULL = all_nines(N);
   localparam logic [BCD_BITS-1:0] NINES = NINES_FULL[BCD_BITS-1:0];

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [BCD_BITS-1:0] scr_q;
   logic [W-1:0]        shf_q;
   logic                sticky_q;

   logic                accept, last;
   logic [BCD_BITS-1:0] adj_all;
   logic [BCD_BITS-1:0] scr_nxt;
   logic [W-1:0]        shf_nxt;
   logic                out_bit;
   logic                sticky_nxt;
   logic [BCD_BITS-1:0] res_nxt;

   for (genvar g = 0; g < N; g++) begin : g_adj
      my_bcd_adj3 u_adj (
         .digit (scr_q[g*BCD_W +: BCD_W]),
         .adj   (adj_all[g*BCD_W +: BCD_W])
      );
   end

   // Add-3 first, then shift the combined {scratch, shift} register; the bit
   // leaving the top digit would belong to digit N, i.e. the value is >= 10^N.
   assign {out_bit, scr_nxt, shf_nxt} = {adj_all, shf_q, 1'b0};
   assign sticky_nxt = sticky_q | out_bit;
   assign res_nxt    = sticky_nxt ? NINES : scr_nxt;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            if (cnt_q == CNT_W'(1)) begin
               last    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_CONV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         scr_q    <= '0;
         shf_q    <= '0;
         sticky_q <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         ovf      <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            cnt_q    <= CNT_W'(W);
            scr_q    <= '0;
            shf_q    <= bin;
            sticky_q <= 1'b0;
         end else if (busy) begin
            cnt_q    <= cnt_q - CNT_W'(1);
            scr_q    <= scr_nxt;
            shf_q    <= shf_nxt;
            sticky_q <= sticky_nxt;
         end
         if (last) begin
            bcd <= res_nxt;
            ovf <= sticky_nxt;
         end
      end
   end

`ifdef MY_BIN2BCD_LZB_EN
   localparam logic [N-1:0] DEN_RST = N'(1);

   logic [N-1:0] den_nxt;

   // Walk from the top digit down: once a nonzero digit is seen, it and every
   // lower digit are shown.
   always_comb begin
      logic seen;
      seen    = 1'b0;
      den_nxt = '0;
      for (int unsigned k = N; k > 0; k--) begin
         if (res_nxt[(k-1)*BCD_W +: BCD_W] != '0) begin
            seen = 1'b1;
         end
         den_nxt[k-1] = seen;
      end
      den_nxt[0] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_en <= DEN_RST;
      end else if (last) begin
         digit_en <= den_nxt;
      end
   end
`else
   assign digit_en = '1;
`endif

endmodule

// File: tb/tb_my_bin2bcd.sv
// tb_my_bin2bcd
//   Directed self-checking bench for my_bin2bcd (W=14, N=4). Expected values
//   are hand-computed constants; digit_en expectations follow the
//   MY_BIN2BCD_LZB_EN build option.
module tb_my_bin2bcd;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin;
   logic        busy;
   logic        done;
   logic [15:0] bcd;
   logic        ovf;
   logic [3:0]  digit_en;

   int n_chk  = 0;
   int n_pass = 0;

   my_bin2bcd #(.W(14), .N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .ovf      (ovf),
      .digit_en (digit_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MY_BIN2BCD_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   function automatic logic [3:0] exp_en(input logic [3:0] lzb_val);
      return LZB ? lzb_val : 4'b1111;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one conversion; optionally inject an extra start (bin=42) on the
   // inj-th busy cycle. Returns at the negedge of the done cycle.
   task automatic run_conv(input logic [13:0] v, input int inj,
                           output int busy_n, output logic got_done);
      busy_n   = 0;
      got_done = 1'b0;
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = 14'h2AAA;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) busy_n++;
         if (inj != 0 && busy_n == inj) begin
            start = 1'b1;
            bin   = 14'd42;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic conv_and_check(input string tag, input logic [13:0] v, input int inj,
                                 input logic [15:0] e_bcd, input logic e_ovf,
                                 input logic [3:0] e_en);
      int   bn;
      logic gd;
      run_conv(v, inj, bn, gd);
      check({tag, "_done"}, 32'(gd), 32'd1);
      check({tag, "_busy_cycles"}, 32'(bn), 32'd14);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      check({tag, "_bcd"}, 32'(bcd), 32'(e_bcd));
      check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
      check({tag, "_en"}, 32'(digit_en), 32'(e_en));
      @(negedge clk);
      check({tag, "_done_1cyc"}, 32'(done), 32'd0);
      check({tag, "_bcd_hold"}, 32'(bcd), 32'(e_bcd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc, last_cyc, n_done, bn;
      logic seen_done, gd;

      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd", 32'(bcd), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_en", 32'(digit_en), 32'(exp_en(4'b0001)));
      rst = 1'b0;
      @(negedge clk);

      conv_and_check("zero",  14'd0,     0, 16'h0000, 1'b0, exp_en(4'b0001));
      conv_and_check("d9999", 14'd9999,  0, 16'h9999, 1'b0, 4'b1111);
      conv_and_check("d10000",14'd10000, 0, 16'h9999, 1'b1, 4'b1111);
      conv_and_check("d16383",14'd16383, 0, 16'h9999, 1'b1, 4'b1111);
      conv_and_check("d305",  14'd305,   5, 16'h0305, 1'b0, exp_en(4'b0111));
      repeat (3) @(negedge clk);
      check("ignored_start_busy", 32'(busy), 32'd0);
      check("ignored_start_bcd", 32'(bcd), 32'h0305);

      // start held high: back-to-back conversions every W+1 cycles
      @(negedge clk);
      bin      = 14'd1234;
      start    = 1'b1;
      cyc      = 0;
      last_cyc = -1;
      n_done   = 0;
      for (int i = 0; i < 100 && n_done < 3; i++) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            n_done++;
            check("held_bcd", 32'(bcd), 32'h1234);
            check("held_en", 32'(digit_en), 32'hF);
            if (last_cyc >= 0) check("held_interval", 32'(cyc - last_cyc), 32'd15);
            last_cyc = cyc;
         end
      end
      check("held_count", 32'(n_done), 32'd3);
      start = 1'b0;
      for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
      check("held_drained", 32'(busy), 32'd0);
      @(negedge clk);

      // reset in the middle of a conversion of 777
      bin   = 14'd777;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      bn = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 40 && bn < 6; i++) begin
         @(negedge clk);
         if (busy) bn++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bcd", 32'(bcd), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      check("abort_en", 32'(digit_en), 32'(exp_en(4'b0001)));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);

      conv_and_check("d777", 14'd777, 0, 16'h0777, 1'b0, exp_en(4'b0111));
      run_conv(14'd1234, 0, bn, gd);
      check("d1234_done", 32'(gd), 32'd1);
      check("d1234_bcd", 32'(bcd), 32'h1234);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/my_bin2bcd.md
# my_bin2bcd

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the multiplexed 7-segment driver. It converts a W-bit binary count into N packed BCD digits and holds them stable on `bcd`, so they can drive the driver's `num[N*4-1:0]` input unchanged. A start/busy/done handshake lets a counter or sensor front-end launch a conversion whenever it has a new value.

## Interface
- `W`, default 14: binary input width; legal range 1..32.
- `N`, default 4: BCD digit count; `bcd` is N*4 bits, digit 0 in bits [3:0].
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset; asynchronous, active-high.
- `start` input, 1 bit: request a conversion; sampled only while `busy`=0.
- `bin` input, W bits: value to convert; captured on the accepting edge only.
- `busy` output, 1 bit: high while a conversion is in progress.
- `done` output, 1 bit: one-cycle pulse when `bcd`/`ovf`/`digit_en` have just updated.
- `bcd` output, N*4 bits: last result; held until the next `done`.
- `ovf` output, 1 bit: last result overflowed (`bin` ≥ 10^N).
- `digit_en` output, N bits: per-digit display enable (see Configuration).

## Operation
- Two states:
  - IDLE: `busy`=0.
  - CONV: `busy`=1.
- IDLE→CONV when `start`=1 at a rising edge. On that edge:
  - `bin` is loaded into the shift register.
  - The scratch BCD register clears.
  - The bit counter loads W.
- CONV, each edge:
  - Every scratch digit ≥5 gets +3.
  - The {scratch, shift} register then shifts left by 1.
  - The counter decrements.
- Overflow detect: the bit shifted out of the top scratch digit is ORed into a sticky flag, which clears on accept.
- On the edge where the counter reaches 0 (final shift), state returns to IDLE and, in the same edge:
  - `bcd` ← scratch, or all digits 9 if the sticky flag is set.
  - `ovf` ← sticky flag.
  - `digit_en` updates.
  - `done` ← 1 for exactly one cycle.
- `start` during CONV is ignored and never queued. `bin` changes during CONV have no effect.
- `start`=1 in the `done` cycle is accepted, because the state is already IDLE.
- Reset values: IDLE, `busy`=0, `done`=0, `bcd`=0, `ovf`=0, `digit_en` = N'b0…01 (macro defined) or all ones (macro undefined).
- Reset asserted mid-conversion aborts it: no `done` is produced and outputs return to reset values.
- Arithmetic: the add-3 is 4-bit per digit with no inter-digit carry, applied before the shift, never after the final shift. The counter is $clog2(W+1) bits.

## Timing
- Accept edge E0. `busy` is high in cycles E0+1 … E0+W, covering W shift edges.
- Result, `done`=1 and `busy`=0 all appear after edge E0+W: latency W edges from accept.
- Throughput with `start` held high: one conversion per W+1 cycles (W=14: every 15 cycles).
- `done` is high only in the cycle after edge E0+W. `bcd` is stable in every cycle except across that edge.

## Configuration
- `MY_BIN2BCD_LZB_EN` (leading-zero blanking).
- Defined: `digit_en[k]`=1 iff digit k is nonzero or some higher digit is nonzero. `digit_en[0]` is always 1. On overflow, all ones.
- Undefined: `digit_en` is tied to all ones and the blanking logic is not compiled.

## Structure
- Shared package/header: BCD digit width constant (4), add-3 threshold constant (5), and the all-nines overflow pattern generator.
- One natural sub-module: `my_bcd_adj3`, combinational per-digit "if ≥5 add 3", instantiated N times via generate.
- FSM, counter, shift register and output registers live in `my_bin2bcd`.

## Test plan
- W=14, N=4, `bin`=0, `start` pulse → after 14 edges: `done`=1, `bcd`=0x0000, `ovf`=0, `digit_en`=4'b0001 (LZB) / 4'b1111 (no LZB).
- `bin`=9999 → `bcd`=0x9999, `ovf`=0, `busy` high exactly 14 cycles.
- `bin`=10000 and `bin`=16383 → `bcd`=0x9999, `ovf`=1, `digit_en`=4'b1111.
- `bin`=305 → `bcd`=0x0305, `digit_en`=4'b0111 (LZB). A second `start` with `bin`=42 at cycle 5 of busy → ignored, result still 0x0305.
- `start` held high, `bin`=1234 → `done` every 15 cycles, `bcd`=0x1234 each time, no gap cycles.
- `rst` pulsed at cycle 6 of conversion of 777 → no `done`; `bcd`=0, `busy`=0; the next conversion of 777 → 0x0777.
